pswd_rom_arbiter: RTL and testbench

PSWD_ROM_ARBITER -- requirements
Module: pswd_rom_arbiter

---
 rtl/pswd_rom_arbiter_pkg.sv | 14 +
 rtl/pswd_rom_rr_pick.sv | 20 ++
 rtl/pswd_rom_arbiter.sv | 98 +++++++++
 tb/tb_pswd_rom_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pswd_rom_arbiter_pkg.sv
// rtl/pswd_rom_arbiter_pkg.sv - shared widths and FSM encoding for the ROM read arbiter
package pswd_rom_arbiter_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } arbState_t;

endpackage

// File: rtl/pswd_rom_rr_pick.sv
// rtl/pswd_rom_rr_pick.sv - combinational 2-way round-robin picker (bit0 = id, bit1 = pswd)
module pswd_rom_rr_pick (
    input  logic [1:0] reqs,
    input  logic       lastPswd,
    input  logic [1:0] excludeMask,
    output logic [1:0] winner
);

    logic [1:0] eligible;

    always_comb begin
        eligible = reqs & ~excludeMask;
        winner   = eligible;
        // Tie goes to whichever requester was not served last.
        if (eligible == 2'b11) begin
            winner = lastPswd ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/pswd_rom_arbiter.sv
// rtl/pswd_rom_arbiter.sv - arbitrates id/pswd reads onto one synchronous ROM, one transaction at a time
module pswd_rom_arbiter
    import pswd_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_id,
    input  logic [ADDR_W-1:0] addr_id,
    input  logic              req_pswd,
    input  logic [ADDR_W-1:0] addr_pswd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              gnt_id,
    output logic              gnt_pswd,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid_id,
    output logic              rvalid_pswd,
    output logic              busy
);

    arbState_t  state;
    arbState_t  nextState;
    logic       lastPswd;
    logic [1:0] reqs;
    logic [1:0] excludeMask;
    logic [1:0] winner;
    logic       arbEn;
    logic       doGrant;

    assign reqs    = {req_pswd, req_id};
    assign doGrant = arbEn & (|winner);
    assign busy    = (state != ST_IDLE);

    pswd_rom_rr_pick u_pick (
        .reqs        (reqs),
        .lastPswd    (lastPswd),
        .excludeMask (excludeMask),
        .winner      (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        arbEn       = 1'b0;
        excludeMask = 2'b00;
        case (state)
            ST_IDLE: begin
                arbEn = 1'b1;
                if (|winner) nextState = ST_ADDR;
            end
            ST_ADDR: nextState = ST_WAIT;
            ST_WAIT: nextState = ST_DONE;
            ST_DONE: begin
                // The served requester may still hold req during its rvalid cycle.
                arbEn       = 1'b1;
                excludeMask = lastPswd ? 2'b10 : 2'b01;
                nextState   = (|winner) ? ST_ADDR : ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // lastPswd doubles as the owner of the in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr    <= '0;
            rdata       <= '0;
            gnt_id      <= 1'b0;
            gnt_pswd    <= 1'b0;
            rvalid_id   <= 1'b0;
            rvalid_pswd <= 1'b0;
            lastPswd    <= 1'b1;
        end else begin
            gnt_id      <= doGrant & winner[0];
            gnt_pswd    <= doGrant & winner[1];
            rvalid_id   <= (state == ST_WAIT) & ~lastPswd;
            rvalid_pswd <= (state == ST_WAIT) & lastPswd;
            if (doGrant) begin
                rom_addr <= winner[1] ? addr_pswd : addr_id;
                lastPswd <= winner[1];
            end
            if (state == ST_WAIT) begin
                rdata <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_pswd_rom_arbiter.sv
// tb/tb_pswd_rom_arbiter.sv - directed vector bench for pswd_rom_arbiter with a 1-cycle ROM model
module tb_pswd_rom_arbiter;

    typedef struct {
        logic        rst;
        logic        reqId;
        logic [4:0]  addrId;
        logic        reqPswd;
        logic [4:0]  addrPswd;
        logic [4:0]  expFlags;   // {gnt_id, gnt_pswd, rvalid_id, rvalid_pswd, busy}
        logic [4:0]  expRom;
        logic [23:0] expRdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_id;
    logic [4:0]  addr_id;
    logic        req_pswd;
    logic [4:0]  addr_pswd;
    logic [4:0]  rom_addr;
    logic [23:0] rom_data;
    logic        gnt_id;
    logic        gnt_pswd;
    logic [23:0] rdata;
    logic        rvalid_id;
    logic        rvalid_pswd;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= 24'hA50000 | {19'd0, rom_addr};

    pswd_rom_arbiter #(.ADDR_W(5), .DATA_W(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_id      (req_id),
        .addr_id     (addr_id),
        .req_pswd    (req_pswd),
        .addr_pswd   (addr_pswd),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .gnt_id      (gnt_id),
        .gnt_pswd    (gnt_pswd),
        .rdata       (rdata),
        .rvalid_id   (rvalid_id),
        .rvalid_pswd (rvalid_pswd),
        .busy        (busy)
    );

    always @(negedge clk) begin
        checks++;
        if ((gnt_id && gnt_pswd) || (rvalid_id && rvalid_pswd)) begin
            failures++;
            $display("FAIL exclusive gnt=%b%b rvalid=%b%b required no overlap",
                     gnt_id, gnt_pswd, rvalid_id, rvalid_pswd);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkOut(input string name, input logic [4:0] f,
                            input logic [4:0] ra, input logic [23:0] rd);
        check({name, ".flags"}, 32'({gnt_id, gnt_pswd, rvalid_id, rvalid_pswd, busy}), 32'(f));
        check({name, ".rom_addr"}, 32'(rom_addr), 32'(ra));
        check({name, ".rdata"}, 32'(rdata), 32'(rd));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic ri, input logic [4:0] ai,
                                input logic rp, input logic [4:0] ap, input logic [4:0] f,
                                input logic [4:0] ra, input logic [23:0] rd);
        vec_t v;
        v.rst = r; v.reqId = ri; v.addrId = ai; v.reqPswd = rp; v.addrPswd = ap;
        v.expFlags = f; v.expRom = ra; v.expRdata = rd;
        return v;
    endfunction

    initial begin
        rst = 1'b1; req_id = 1'b0; addr_id = '0; req_pswd = 1'b0; addr_pswd = '0;

        // Lone id read of 0x03
        vecs.push_back(mk(0, 1, 5'h03, 0, 5'h00, 5'b10001, 5'h03, 24'h000000));
        vecs.push_back(mk(0, 1, 5'h03, 0, 5'h00, 5'b00001, 5'h03, 24'h000000));
        vecs.push_back(mk(0, 1, 5'h03, 0, 5'h00, 5'b00101, 5'h03, 24'hA50003));
        vecs.push_back(mk(0, 0, 5'h03, 0, 5'h00, 5'b00000, 5'h03, 24'hA50003));
        vecs.push_back(mk(0, 0, 5'h00, 0, 5'h00, 5'b00000, 5'h03, 24'hA50003));
        // Reset, then simultaneous requests: id first, pswd straight from DONE
        vecs.push_back(mk(1, 0, 5'h00, 0, 5'h00, 5'b00000, 5'h00, 24'h000000));
        vecs.push_back(mk(0, 1, 5'h01, 1, 5'h1F, 5'b10001, 5'h01, 24'h000000));
        vecs.push_back(mk(0, 1, 5'h01, 1, 5'h1F, 5'b00001, 5'h01, 24'h000000));
        vecs.push_back(mk(0, 1, 5'h01, 1, 5'h1F, 5'b00101, 5'h01, 24'hA50001));
        vecs.push_back(mk(0, 0, 5'h01, 1, 5'h1F, 5'b01001, 5'h1F, 24'hA50001));
        vecs.push_back(mk(0, 0, 5'h01, 1, 5'h1F, 5'b00001, 5'h1F, 24'hA50001));
        vecs.push_back(mk(0, 0, 5'h01, 1, 5'h1F, 5'b00011, 5'h1F, 24'hA5001F));
        vecs.push_back(mk(0, 0, 5'h01, 0, 5'h1F, 5'b00000, 5'h1F, 24'hA5001F));
        // Both held for four transactions: id, pswd, id, pswd
        vecs.push_back(mk(0, 1, 5'h04, 1, 5'h09, 5'b10001, 5'h04, 24'hA5001F));
        vecs.push_back(mk(0, 1, 5'h04, 1, 5'h09, 5'b00001, 5'h04, 24'hA5001F));
        vecs.push_back(mk(0, 1, 5'h04, 1, 5'h09, 5'b00101, 5'h04, 24'hA50004));
        vecs.push_back(mk(0, 1, 5'h04, 1, 5'h09, 5'b01001, 5'h09, 24'hA50004));
        vecs.push_back(mk(0, 1, 5'h04, 1, 5'h09, 5'b00001, 5'h09, 24'hA50004));
        vecs.push_back(mk(0, 1, 5'h04, 1, 5'h09, 5'b00011, 5'h09, 24'hA50009));
        vecs.push_back(mk(0, 1, 5'h04, 1, 5'h09, 5'b10001, 5'h04, 24'hA50009));
        vecs.push_back(mk(0, 1, 5'h04, 1, 5'h09, 5'b00001, 5'h04, 24'hA50009));
        vecs.push_back(mk(0, 1, 5'h04, 1, 5'h09, 5'b00101, 5'h04, 24'hA50004));
        vecs.push_back(mk(0, 1, 5'h04, 1, 5'h09, 5'b01001, 5'h09, 24'hA50004));
        vecs.push_back(mk(0, 1, 5'h04, 1, 5'h09, 5'b00001, 5'h09, 24'hA50004));
        vecs.push_back(mk(0, 1, 5'h04, 1, 5'h09, 5'b00011, 5'h09, 24'hA50009));
        vecs.push_back(mk(0, 0, 5'h04, 0, 5'h09, 5'b00000, 5'h09, 24'hA50009));

        tick();
        tick();
        checkOut("reset", 5'b00000, 5'h00, 24'h000000);

        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            req_id = vecs[i].reqId;
            addr_id = vecs[i].addrId;
            req_pswd = vecs[i].reqPswd;
            addr_pswd = vecs[i].addrPswd;
            tick();
            checkOut($sformatf("vec%0d", i), vecs[i].expFlags, vecs[i].expRom, vecs[i].expRdata);
        end

        // Asynchronous reset during WAIT of a pswd read
        req_pswd = 1'b1; addr_pswd = 5'h0A;
        tick();
        checkOut("rst_mid.gnt", 5'b01001, 5'h0A, 24'hA50009);
        tick();
        checkOut("rst_mid.wait", 5'b00001, 5'h0A, 24'hA50009);
        rst = 1'b1; req_pswd = 1'b0;
        #1;
        checkOut("rst_mid.async", 5'b00000, 5'h00, 24'h000000);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOut($sformatf("rst_mid.quiet%0d", i), 5'b00000, 5'h00, 24'h000000);
        end
        req_pswd = 1'b1;
        tick();
        checkOut("rst_after.gnt", 5'b01001, 5'h0A, 24'h000000);
        tick();
        tick();
        checkOut("rst_after.rvalid", 5'b00011, 5'h0A, 24'hA5000A);
        req_pswd = 1'b0;
        tick();
        checkOut("rst_after.idle", 5'b00000, 5'h0A, 24'hA5000A);

        // pswd drops its request right after the grant
        req_pswd = 1'b1; addr_pswd = 5'h11;
        tick();
        checkOut("drop.gnt", 5'b01001, 5'h11, 24'hA5000A);
        req_pswd = 1'b0;
        tick();
        checkOut("drop.wait", 5'b00001, 5'h11, 24'hA5000A);
        tick();
        checkOut("drop.rvalid", 5'b00011, 5'h11, 24'hA50011);
        tick();
        checkOut("drop.idle", 5'b00000, 5'h11, 24'hA50011);

        // id address changes during WAIT
        req_id = 1'b1; addr_id = 5'h02;
        tick();
        checkOut("addrchg.gnt", 5'b10001, 5'h02, 24'hA50011);
        tick();
        addr_id = 5'h07;
        tick();
        checkOut("addrchg.rvalid", 5'b00101, 5'h02, 24'hA50002);
        req_id = 1'b0;
        tick();
        checkOut("addrchg.idle", 5'b00000, 5'h02, 24'hA50002);
        tick();
        checkOut("addrchg.hold", 5'b00000, 5'h02, 24'hA50002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
